// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and the
// signed-overflow rule applied to the final result bit.
package serial_subtractor_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb ^ b_msb) & (d_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_ctrl_full_subtractor.sv
// One-bit full subtractor: D = a - b - Bin, Bout set when the bit underflows.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    assign D    = a ^ b ^ Bin;
    assign Bout = (~a & b) | (~(a ^ b) & Bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: a - b - bin through a single full_subtractor
// cell, LSB first, with valid/ready handshakes on operands and result.
module serial_subtractor_ctrl
    import serial_subtractor_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNTW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_sh, b_sh, diff_r;
    logic [CNTW-1:0]    cnt;
    logic               brw, a_msb, b_msb, bout_r, ovf_r;
    logic               cell_d, cell_bo;
    logic               last_bit;

    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .Bin  (brw),
        .D    (cell_d),
        .Bout (cell_bo)
    );

    assign last_bit = (cnt == CNTW'(WIDTH - 1));

    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        busy        = 1'b0;
        done_valid  = 1'b0;
        unique case (state)
            S_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_bit) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy       = 1'b1;
                done_valid = 1'b1;
                if (done_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // bout/ovf are registered on the final RUN edge so they stay put through
    // DONE and after the handshake, independent of later shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            diff_r <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        brw   <= bin;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                    end
                end
                S_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    diff_r <= {cell_d, diff_r[WIDTH-1:1]};
                    brw    <= cell_bo;
                    if (last_bit) begin
                        bout_r <= cell_bo;
                        ovf_r  <= signed_ovf(a_msb, b_msb, cell_d);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = diff_r;
    assign bout = bout_r;
    assign ovf  = ovf_r;

endmodule
